// File: rtl/eight_bit_shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM encoding, step count
// and the partial-product gating helper.
package eight_bit_shift_add_multiplier_pkg;

  localparam int unsigned MUL_WIDTH = 8;
  localparam int unsigned MUL_STEPS = 8;
  localparam int unsigned CNT_WIDTH = 4;

  localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(MUL_STEPS - 1);

  typedef logic [MUL_WIDTH-1:0]   operand_t;
  typedef logic [2*MUL_WIDTH-1:0] product_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  // The adder's B operand: the multiplicand when the current multiplier bit is set.
  function automatic operand_t gate_operand(input logic sel, input operand_t m);
    return sel ? m : '0;
  endfunction

endpackage

// File: rtl/eight_bit_ripple_carry_adder.sv
// Purely combinational 8-bit ripple-carry adder built from a chain of full adders.
module eight_bit_ripple_carry_adder (
  output logic       C_out,
  output logic [7:0] S,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       C_in
);

  logic [8:0] carry;

  assign carry[0] = C_in;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_fa
      assign S[gi]         = A[gi] ^ B[gi] ^ carry[gi];
      assign carry[gi + 1] = (A[gi] & B[gi]) | (carry[gi] & (A[gi] ^ B[gi]));
    end
  endgenerate

  assign C_out = carry[8];

endmodule

// File: rtl/eight_bit_shift_add_multiplier.sv
// Sequential 8x8 unsigned shift-and-add multiplier: one multiplier bit per clock,
// one shared ripple-carry adder, start/done handshake with a held result.
module eight_bit_shift_add_multiplier
  import eight_bit_shift_add_multiplier_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  mul_state_e           state_q;
  operand_t             m_q;
  operand_t             acc_q;
  operand_t             q_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 busy_q;
  logic                 done_q;

  operand_t             addend;
  operand_t             sum;
  logic                 carry;
  operand_t             acc_d;
  operand_t             q_d;
  logic [CNT_WIDTH-1:0] cnt_d;

  assign addend = gate_operand(q_q[0], m_q);

  eight_bit_ripple_carry_adder u_adder (
    .C_out (carry),
    .S     (sum),
    .A     (acc_q),
    .B     (addend),
    .C_in  (1'b0)
  );

  // Right shift of {carry, sum, Q}: the carry becomes the new ACC MSB and the
  // consumed multiplier bit falls off the bottom of Q.
  assign {acc_d, q_d} = {carry, sum, q_q[MUL_WIDTH-1:1]};
  assign cnt_d        = cnt_q + CNT_WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RUN;
            m_q     <= a;
            q_q     <= b;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          cnt_q <= cnt_d;
          if (cnt_q == LAST_STEP) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = {acc_q, q_q};

endmodule
